// File: rtl/tfcall_pkg.sv
// Shared definitions for the task/function call responder: data widths,
// function ids, error codes, FSM state encoding and the per-function arity table.
package tfcall_pkg;

  localparam int unsigned DATA_W  = 8;
  localparam int unsigned NARGS_W = 3;
  localparam int unsigned DBL_W   = 4;
  localparam int unsigned FUNC_W  = 2;
  localparam int unsigned ERR_W   = 2;

  localparam logic [FUNC_W-1:0] FN_SUM     = 2'd0;
  localparam logic [FUNC_W-1:0] FN_DOUBLE  = 2'd1;
  localparam logic [FUNC_W-1:0] FN_NO_ARGS = 2'd2;
  localparam logic [FUNC_W-1:0] FN_UNDEF   = 2'd3;

  localparam logic [ERR_W-1:0] ERR_OK       = 2'd0;
  localparam logic [ERR_W-1:0] ERR_TOO_FEW  = 2'd1;
  localparam logic [ERR_W-1:0] ERR_TOO_MANY = 2'd2;
  localparam logic [ERR_W-1:0] ERR_UNDEF    = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ARGS = 2'd1,
    ST_EXEC = 2'd2,
    ST_RESP = 2'd3
  } state_t;

  // Call header as latched on acceptance
  typedef struct packed {
    logic [FUNC_W-1:0]  func;
    logic [NARGS_W-1:0] nargs;
    logic               discard;
  } call_hdr_t;

  // Expected argument count per function id (undefined id reports 0; it errors anyway)
  function automatic logic [NARGS_W-1:0] func_arity(input logic [FUNC_W-1:0] fn);
    logic [NARGS_W-1:0] ar;
    case (fn)
      FN_SUM:    ar = NARGS_W'(2);
      FN_DOUBLE: ar = NARGS_W'(1);
      default:   ar = NARGS_W'(0);
    endcase
    return ar;
  endfunction

endpackage

// File: rtl/tfcall_eval.sv
// Combinational evaluator: arity check and built-in function result.
// Ports:
//   i_func      function id
//   i_nargs     number of argument beats the caller sent
//   i_a0, i_a1  first two captured arguments
//   o_result_c  function result (0 whenever an error is reported)
//   o_err_c     error code
module tfcall_eval
  import tfcall_pkg::*;
(
  input  logic [FUNC_W-1:0]  i_func,
  input  logic [NARGS_W-1:0] i_nargs,
  input  logic [DATA_W-1:0]  i_a0,
  input  logic [DATA_W-1:0]  i_a1,
  output logic [DATA_W-1:0]  o_result_c,
  output logic [ERR_W-1:0]   o_err_c
);

  logic [NARGS_W-1:0] w_arity;

  // Undefined id wins over arity; result only driven on success
  always_comb begin
    w_arity    = func_arity(i_func);
    o_err_c    = ERR_OK;
    o_result_c = '0;
    if (i_func == FN_UNDEF) begin
      o_err_c = ERR_UNDEF;
    end else if (i_nargs < w_arity) begin
      o_err_c = ERR_TOO_FEW;
    end else if (i_nargs > w_arity) begin
      o_err_c = ERR_TOO_MANY;
    end else begin
      case (i_func)
        FN_SUM:     o_result_c = i_a0 + i_a1;
        // Shift left within DBL_W bits drops the top operand bit, zero-extended
        FN_DOUBLE:  o_result_c = DATA_W'({i_a0[DBL_W-2:0], 1'b0});
        FN_NO_ARGS: o_result_c = DATA_W'(1);
        default:    o_result_c = '0;
      endcase
    end
  end

endmodule

// File: rtl/tfcall_responder.sv
// Callee end of the call channel: accepts a header, drains the argument
// stream, evaluates the function and returns a result or error code.
// Ports:
//   clk, rst_n                      clock, synchronous active-low reset
//   call_valid/ready, call_func,
//   call_nargs, call_discard        call header handshake (ready only in IDLE)
//   arg_valid/ready, arg_data       argument stream (ready only while draining)
//   ret_valid/ready, ret_data,
//   ret_err                         response, held until accepted
module tfcall_responder
  import tfcall_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               call_valid,
  output logic               call_ready,
  input  logic [FUNC_W-1:0]  call_func,
  input  logic [NARGS_W-1:0] call_nargs,
  input  logic               call_discard,
  input  logic               arg_valid,
  output logic               arg_ready,
  input  logic [DATA_W-1:0]  arg_data,
  output logic               ret_valid,
  input  logic               ret_ready,
  output logic [DATA_W-1:0]  ret_data,
  output logic [ERR_W-1:0]   ret_err
);

  state_t             r_state,      w_state_nxt;
  call_hdr_t          r_hdr,        w_hdr_nxt;
  logic [NARGS_W-1:0] r_cnt,        w_cnt_nxt;
  logic [DATA_W-1:0]  r_a0,         w_a0_nxt;
  logic [DATA_W-1:0]  r_a1,         w_a1_nxt;
  logic               r_call_ready, w_call_ready_nxt;
  logic               r_arg_ready,  w_arg_ready_nxt;
  logic               r_ret_valid,  w_ret_valid_nxt;
  logic [DATA_W-1:0]  r_ret_data,   w_ret_data_nxt;
  logic [ERR_W-1:0]   r_ret_err,    w_ret_err_nxt;

  logic [DATA_W-1:0]  w_result;
  logic [ERR_W-1:0]   w_err;

  tfcall_eval u_eval (
    .i_func     (r_hdr.func),
    .i_nargs    (r_hdr.nargs),
    .i_a0       (r_a0),
    .i_a1       (r_a1),
    .o_result_c (w_result),
    .o_err_c    (w_err)
  );

  // State and output registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state      <= ST_IDLE;
      r_hdr        <= '0;
      r_cnt        <= '0;
      r_a0         <= '0;
      r_a1         <= '0;
      r_call_ready <= 1'b1;
      r_arg_ready  <= 1'b0;
      r_ret_valid  <= 1'b0;
      r_ret_data   <= '0;
      r_ret_err    <= ERR_OK;
    end else begin
      r_state      <= w_state_nxt;
      r_hdr        <= w_hdr_nxt;
      r_cnt        <= w_cnt_nxt;
      r_a0         <= w_a0_nxt;
      r_a1         <= w_a1_nxt;
      r_call_ready <= w_call_ready_nxt;
      r_arg_ready  <= w_arg_ready_nxt;
      r_ret_valid  <= w_ret_valid_nxt;
      r_ret_data   <= w_ret_data_nxt;
      r_ret_err    <= w_ret_err_nxt;
    end
  end

  // Next-state and next-output logic
  always_comb begin
    w_state_nxt     = r_state;
    w_hdr_nxt       = r_hdr;
    w_cnt_nxt       = r_cnt;
    w_a0_nxt        = r_a0;
    w_a1_nxt        = r_a1;
    w_ret_valid_nxt = r_ret_valid;
    w_ret_data_nxt  = r_ret_data;
    w_ret_err_nxt   = r_ret_err;

    case (r_state)
      ST_IDLE: begin
        if (call_valid && r_call_ready) begin
          w_hdr_nxt.func    = call_func;
          w_hdr_nxt.nargs   = call_nargs;
          w_hdr_nxt.discard = call_discard;
          w_cnt_nxt         = '0;
          w_a0_nxt          = '0;
          w_a1_nxt          = '0;
          w_state_nxt       = (call_nargs == '0) ? ST_EXEC : ST_ARGS;
        end
      end
      ST_ARGS: begin
        if (arg_valid && r_arg_ready) begin
          // Only the first two beats matter; the rest are drained and dropped
          if (r_cnt == NARGS_W'(0)) w_a0_nxt = arg_data;
          if (r_cnt == NARGS_W'(1)) w_a1_nxt = arg_data;
          w_cnt_nxt = r_cnt + NARGS_W'(1);
          if (r_cnt == r_hdr.nargs - NARGS_W'(1)) w_state_nxt = ST_EXEC;
        end
      end
      ST_EXEC: begin
        if ((w_err == ERR_OK) && r_hdr.discard) begin
          w_state_nxt = ST_IDLE;
        end else begin
          w_ret_valid_nxt = 1'b1;
          w_ret_data_nxt  = w_result;
          w_ret_err_nxt   = w_err;
          w_state_nxt     = ST_RESP;
        end
      end
      ST_RESP: begin
        if (ret_ready) begin
          w_ret_valid_nxt = 1'b0;
          w_ret_data_nxt  = '0;
          w_ret_err_nxt   = ERR_OK;
          w_state_nxt     = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase

    // Handshake readies follow the state being entered so they are valid on arrival
    w_call_ready_nxt = (w_state_nxt == ST_IDLE);
    w_arg_ready_nxt  = (w_state_nxt == ST_ARGS);
  end

  assign call_ready = r_call_ready;
  assign arg_ready  = r_arg_ready;
  assign ret_valid  = r_ret_valid;
  assign ret_data   = r_ret_data;
  assign ret_err    = r_ret_err;

endmodule

// File: tb/tb_tfcall_responder.sv
// Bench for tfcall_responder: directed cases then random calls, each checked
// against an arithmetic reference model of the call semantics.
module tb_tfcall_responder;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       call_valid = 1'b0;
  logic       call_ready;
  logic [1:0] call_func = 2'd0;
  logic [2:0] call_nargs = 3'd0;
  logic       call_discard = 1'b0;
  logic       arg_valid = 1'b0;
  logic       arg_ready;
  logic [7:0] arg_data = 8'd0;
  logic       ret_valid;
  logic       ret_ready = 1'b0;
  logic [7:0] ret_data;
  logic [1:0] ret_err;

  int n_assert = 0;
  int n_fail   = 0;
  int tb_args [8];

  tfcall_responder dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .call_valid   (call_valid),
    .call_ready   (call_ready),
    .call_func    (call_func),
    .call_nargs   (call_nargs),
    .call_discard (call_discard),
    .arg_valid    (arg_valid),
    .arg_ready    (arg_ready),
    .arg_data     (arg_data),
    .ret_valid    (ret_valid),
    .ret_ready    (ret_ready),
    .ret_data     (ret_data),
    .ret_err      (ret_err)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Reference: arity table, error precedence and function results as plain arithmetic
  function automatic void model(input int fn, input int nargs, input bit disc,
                                output bit resp, output int d, output int e);
    int ar;
    ar = (fn == 0) ? 2 : (fn == 1) ? 1 : 0;
    if (fn == 3)         e = 3;
    else if (nargs < ar) e = 1;
    else if (nargs > ar) e = 2;
    else                 e = 0;
    d = 0;
    if (e == 0) begin
      if (fn == 0)      d = (tb_args[0] + tb_args[1]) % 256;
      else if (fn == 1) d = ((tb_args[0] % 16) * 2) % 16;
      else              d = 1;
    end
    resp = !(e == 0 && disc);
  endfunction

  // One complete call: header, args (optionally gapped), response held for 'hold' cycles
  task automatic run_call(input int fn, input int nargs, input bit disc, input int hold,
                          input bit gaps, output logic [7:0] od, output logic [1:0] oe);
    bit exp_r;
    int exp_d, exp_e;
    model(fn, nargs, disc, exp_r, exp_d, exp_e);
    check("idle_call_ready", call_ready, 1);
    call_valid   = 1'b1;
    call_func    = 2'(fn);
    call_nargs   = 3'(nargs);
    call_discard = disc;
    tick();
    call_valid   = 1'b0;
    call_func    = 2'($urandom);
    call_nargs   = 3'($urandom);
    call_discard = 1'($urandom);
    for (int i = 0; i < nargs; i++) begin
      if (gaps && ($urandom_range(0, 1) == 1)) begin
        arg_valid = 1'b0;
        tick();
      end
      check("args_arg_ready", arg_ready, 1);
      arg_valid = 1'b1;
      arg_data  = 8'(tb_args[i]);
      tick();
      arg_valid = 1'b0;
    end
    check("exec_ret_valid", ret_valid, 0);
    check("exec_call_ready", call_ready, 0);
    check("exec_arg_ready", arg_ready, 0);
    tick();
    od = ret_data;
    oe = ret_err;
    if (exp_r) begin
      check("resp_ret_valid", ret_valid, 1);
      check("resp_ret_data", ret_data, exp_d);
      check("resp_ret_err", ret_err, exp_e);
      for (int h = 0; h < hold; h++) begin
        call_valid = 1'b1;
        arg_valid  = 1'b1;
        arg_data   = 8'($urandom);
        tick();
        check("hold_ret_valid", ret_valid, 1);
        check("hold_ret_data", ret_data, exp_d);
        check("hold_ret_err", ret_err, exp_e);
        check("hold_call_ready", call_ready, 0);
        check("hold_arg_ready", arg_ready, 0);
      end
      ret_ready = 1'b1;
      tick();
      ret_ready  = 1'b0;
      call_valid = 1'b0;
      arg_valid  = 1'b0;
      check("done_ret_valid", ret_valid, 0);
      check("done_call_ready", call_ready, 1);
    end else begin
      check("discard_ret_valid", ret_valid, 0);
      check("discard_call_ready", call_ready, 1);
    end
  endtask

  initial begin
    logic [7:0] od;
    logic [1:0] oe;
    int fn, na, hold;
    bit disc;

    // Reset state
    tick();
    tick();
    rst_n = 1'b1;
    check("rst_call_ready", call_ready, 1);
    check("rst_arg_ready", arg_ready, 0);
    check("rst_ret_valid", ret_valid, 0);
    check("rst_ret_data", ret_data, 0);
    check("rst_ret_err", ret_err, 0);

    // SUM 200+100 wraps to 44
    tb_args[0] = 200; tb_args[1] = 100;
    run_call(0, 2, 1'b0, 0, 1'b0, od, oe);
    check("sum_wrap_data", od, 44);
    check("sum_wrap_err", oe, 0);

    // DOUBLE 0x0F keeps low 4 bits: 0x0E
    tb_args[0] = 8'h0F;
    run_call(1, 1, 1'b0, 0, 1'b0, od, oe);
    check("double_data", od, 8'h0E);

    // NO_ARGS returns 1
    run_call(2, 0, 1'b0, 0, 1'b0, od, oe);
    check("noargs_data", od, 1);

    // SUM with one arg: TOO_FEW
    tb_args[0] = 5;
    run_call(0, 1, 1'b0, 0, 1'b0, od, oe);
    check("sum_too_few_err", oe, 1);
    check("sum_too_few_data", od, 0);

    // SUM with three args: TOO_MANY, all drained
    tb_args[0] = 1; tb_args[1] = 2; tb_args[2] = 3;
    run_call(0, 3, 1'b0, 0, 1'b0, od, oe);
    check("sum_too_many_err", oe, 2);

    // Undefined function
    tb_args[0] = 77;
    run_call(3, 1, 1'b0, 0, 1'b0, od, oe);
    check("undef_err", oe, 3);
    check("undef_data", od, 0);

    // Discarded success produces nothing; discarded error still reported
    run_call(2, 0, 1'b1, 0, 1'b0, od, oe);
    tb_args[0] = 9;
    run_call(2, 1, 1'b1, 0, 1'b0, od, oe);
    check("discard_err_err", oe, 2);

    // Backpressure on the response for 5 cycles
    tb_args[0] = 10; tb_args[1] = 20;
    run_call(0, 2, 1'b0, 5, 1'b0, od, oe);
    check("hold_sum_data", od, 30);

    // Reset after first of two SUM args abandons the call
    call_valid = 1'b1; call_func = 2'd0; call_nargs = 3'd2; call_discard = 1'b0;
    tick();
    call_valid = 1'b0;
    arg_valid  = 1'b1; arg_data = 8'd9;
    tick();
    arg_valid = 1'b0;
    rst_n     = 1'b0;
    tick();
    rst_n = 1'b1;
    check("midrst_call_ready", call_ready, 1);
    check("midrst_arg_ready", arg_ready, 0);
    check("midrst_ret_valid", ret_valid, 0);
    check("midrst_ret_data", ret_data, 0);
    check("midrst_ret_err", ret_err, 0);
    tick();
    tick();
    check("midrst_quiet", ret_valid, 0);
    tb_args[0] = 3; tb_args[1] = 4;
    run_call(0, 2, 1'b0, 0, 1'b0, od, oe);
    check("post_rst_sum", od, 7);

    // Random calls against the model
    for (int k = 0; k < 60; k++) begin
      fn   = $urandom_range(0, 3);
      na   = $urandom_range(0, 7);
      disc = 1'($urandom);
      hold = $urandom_range(0, 3);
      for (int i = 0; i < 8; i++) tb_args[i] = $urandom_range(0, 255);
      run_call(fn, na, disc, hold, 1'b1, od, oe);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
